// File: rtl/expr_verify.sv
// ---------------------------------------------------------------------------
// expr_verify
//
// Streaming syntax checker for infix arithmetic expressions. Characters come
// in one per char_valid strobe, and frames are delimited by NUL (0x00). Each
// completed frame produces one verdict. Grammar:
//    expr := term (op term)*
//    term := number | letter | '(' expr ')'
// Spaces are ignored, except that a space ends a number.
//
// Error codes reported on err_code:
//    0 ok, 1 syntax, 2 unmatched closer, 3 nesting too deep,
//    4 number too long, 5 incomplete / empty frame, 6 bracket type clash
//
// Optional feature macro: EXPR_VERIFY_MULTI_BRACKET_EN
//    When defined, '[' ']' '{' '}' are brackets as well, and a small type
//    stack checks that every closer matches its opener (code 6 otherwise).
//    When undefined, those characters are illegal and no stack is built.
//
// Parameters:
//    MAX_DEPTH   maximum bracket nesting depth (1..255)
//    MAX_DIGITS  maximum digits in one numeric literal (1..15)
//    CNT_W       width of the valid/invalid frame counters
//
// Ports:
//    clk             system clock, rising edge
//    rst             asynchronous active-low reset
//    ascii_char      character code, sampled when char_valid = 1
//    char_valid      one-cycle qualifier, back-to-back allowed
//    sequence_valid  verdict of the last completed frame (err_code == 0)
//    output_strobe   one-cycle pulse when the verdict is updated
//    err_code        reason for the last verdict
//    depth           current bracket nesting depth (debug)
//    ok_cnt          number of valid frames, wraps
//    bad_cnt         number of invalid frames, wraps
// ---------------------------------------------------------------------------
module expr_verify #(
    parameter int MAX_DEPTH  = 8,
    parameter int MAX_DIGITS = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ascii_char,
    input  logic             char_valid,
    output logic             sequence_valid,
    output logic             output_strobe,
    output logic [2:0]       err_code,
    output logic [7:0]       depth,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam logic [2:0] CODE_OK         = 3'd0;
    localparam logic [2:0] CODE_SYNTAX     = 3'd1;
    localparam logic [2:0] CODE_UNDERFLOW  = 3'd2;
    localparam logic [2:0] CODE_TOO_DEEP   = 3'd3;
    localparam logic [2:0] CODE_LONG_NUM   = 3'd4;
    localparam logic [2:0] CODE_INCOMPLETE = 3'd5;
    localparam logic [2:0] CODE_BAD_PAIR   = 3'd6;

    localparam logic [7:0] DEPTH_LIMIT = 8'(MAX_DEPTH);
    localparam logic [3:0] DIGIT_LIMIT = 4'(MAX_DIGITS);

    typedef enum logic [2:0] {
        IDLE,
        EXP_OPND,
        IN_NUM,
        EXP_OP,
        ERROR,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       depth_q, depth_d;
    logic [3:0]       digits_q, digits_d;
    logic [2:0]       code_q, code_d;
    logic             strobe_q;
    logic             valid_q;
    logic [2:0]       verdict_q;
    logic [CNT_W-1:0] okCnt_q;
    logic [CNT_W-1:0] badCnt_q;

    logic isNul, isDigit, isLetter, isOp, isSpace, isOpen, isClose;
    logic typeMismatch;

    // Character classification. Anything not matched by one of these flags
    // (and not a space) is illegal and leads to a syntax error.
    always_comb begin
        isNul    = (ascii_char == 8'h00);
        isDigit  = (ascii_char >= 8'h30) && (ascii_char <= 8'h39);
        isLetter = ((ascii_char >= 8'h41) && (ascii_char <= 8'h5A)) ||
                   ((ascii_char >= 8'h61) && (ascii_char <= 8'h7A));
        isOp     = (ascii_char == 8'h2B) || (ascii_char == 8'h2D) ||
                   (ascii_char == 8'h2A) || (ascii_char == 8'h2F);
        isSpace  = (ascii_char == 8'h20);
        isOpen   = (ascii_char == 8'h28);
        isClose  = (ascii_char == 8'h29);
`ifdef EXPR_VERIFY_MULTI_BRACKET_EN
        isOpen   = isOpen  || (ascii_char == 8'h5B) || (ascii_char == 8'h7B);
        isClose  = isClose || (ascii_char == 8'h5D) || (ascii_char == 8'h7D);
`endif
    end

`ifdef EXPR_VERIFY_MULTI_BRACKET_EN
    // Type stack: one 2-bit entry per open bracket (0 round, 1 square,
    // 2 curly). The entry at depth-1 is the innermost open bracket.
    localparam int IDX_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    logic [1:0]       stack_q [MAX_DEPTH];
    logic [1:0]       openType, closeType;
    logic [IDX_W-1:0] pushIdx, topIdx;
    logic             push;

    always_comb begin
        openType  = 2'd0;
        closeType = 2'd0;
        if (ascii_char == 8'h5B) openType  = 2'd1;
        if (ascii_char == 8'h7B) openType  = 2'd2;
        if (ascii_char == 8'h5D) closeType = 2'd1;
        if (ascii_char == 8'h7D) closeType = 2'd2;
    end

    assign pushIdx      = IDX_W'(depth_q);
    assign topIdx       = IDX_W'(depth_q - 8'd1);
    assign typeMismatch = (stack_q[topIdx] != closeType);

    // The stack needs no reset: an entry is only read after it was pushed
    // in the current frame, since depth restarts at zero every frame.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[pushIdx] <= openType;
        end
    end
`else
    assign typeMismatch = 1'b0;
`endif

    // Next-state logic. IN_NUM and EXP_OP share one branch because any
    // non-digit inside a number is treated exactly as if the number had
    // already ended. The first error code is latched in code_q and carried
    // through ERROR into DONE.
    always_comb begin
        state_d  = state_q;
        depth_d  = depth_q;
        digits_d = digits_q;
        code_d   = code_q;
`ifdef EXPR_VERIFY_MULTI_BRACKET_EN
        push     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (char_valid && isNul) begin
                    state_d = EXP_OPND;
                    code_d  = CODE_OK;
                end
            end

            EXP_OPND: begin
                if (char_valid) begin
                    if (isDigit) begin
                        state_d  = IN_NUM;
                        digits_d = 4'd1;
                    end else if (isLetter) begin
                        state_d = EXP_OP;
                    end else if (isOpen) begin
                        if (depth_q == DEPTH_LIMIT) begin
                            state_d = ERROR;
                            code_d  = CODE_TOO_DEEP;
                        end else begin
                            depth_d = depth_q + 8'd1;
`ifdef EXPR_VERIFY_MULTI_BRACKET_EN
                            push    = 1'b1;
`endif
                        end
                    end else if (isNul) begin
                        state_d = DONE;
                        code_d  = CODE_INCOMPLETE;
                    end else if (!isSpace) begin
                        state_d = ERROR;
                        code_d  = CODE_SYNTAX;
                    end
                end
            end

            IN_NUM, EXP_OP: begin
                if (char_valid) begin
                    if ((state_q == IN_NUM) && isDigit) begin
                        if (digits_q == DIGIT_LIMIT) begin
                            state_d = ERROR;
                            code_d  = CODE_LONG_NUM;
                        end else begin
                            digits_d = digits_q + 4'd1;
                        end
                    end else begin
                        state_d  = EXP_OP;
                        digits_d = 4'd0;
                        if (isOp) begin
                            state_d = EXP_OPND;
                        end else if (isClose) begin
                            if (depth_q == 8'd0) begin
                                state_d = ERROR;
                                code_d  = CODE_UNDERFLOW;
                            end else if (typeMismatch) begin
                                state_d = ERROR;
                                code_d  = CODE_BAD_PAIR;
                            end else begin
                                depth_d = depth_q - 8'd1;
                            end
                        end else if (isNul) begin
                            state_d = DONE;
                            code_d  = (depth_q == 8'd0) ? CODE_OK : CODE_INCOMPLETE;
                        end else if (!isSpace) begin
                            state_d = ERROR;
                            code_d  = CODE_SYNTAX;
                        end
                    end
                end
            end

            ERROR: begin
                if (char_valid && isNul) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // A character arriving here is handled as in IDLE, so a NUL
                // immediately opens the next frame.
                depth_d  = 8'd0;
                digits_d = 4'd0;
                state_d  = IDLE;
                if (char_valid && isNul) begin
                    state_d = EXP_OPND;
                    code_d  = CODE_OK;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and verdict registers. The verdict, strobe and counters update
    // on the edge that leaves DONE, so the strobe appears one cycle after
    // the edge that accepted the closing NUL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            depth_q   <= 8'd0;
            digits_q  <= 4'd0;
            code_q    <= CODE_OK;
            strobe_q  <= 1'b0;
            valid_q   <= 1'b0;
            verdict_q <= CODE_OK;
            okCnt_q   <= '0;
            badCnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            digits_q <= digits_d;
            code_q   <= code_d;
            strobe_q <= (state_q == DONE);
            if (state_q == DONE) begin
                valid_q   <= (code_q == CODE_OK);
                verdict_q <= code_q;
                if (code_q == CODE_OK) begin
                    okCnt_q <= okCnt_q + CNT_W'(1);
                end else begin
                    badCnt_q <= badCnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign sequence_valid = valid_q;
    assign output_strobe  = strobe_q;
    assign err_code       = verdict_q;
    assign depth          = depth_q;
    assign ok_cnt         = okCnt_q;
    assign bad_cnt        = badCnt_q;

endmodule

// File: tb/tb_expr_verify.sv
// ---------------------------------------------------------------------------
// tb_expr_verify
//
// Drives directed and random NUL-delimited frames into expr_verify. The
// expected verdict of every frame comes from a token-level grammar model:
// the frame body is first split into tokens (numbers, letters, operators,
// brackets, illegal characters), then the token list is checked against
// the grammar. A monitor compares every strobe with the queued expectation.
// ---------------------------------------------------------------------------
module tb_expr_verify;

    localparam int MAX_DEPTH  = 8;
    localparam int MAX_DIGITS = 4;
    localparam int CNT_W      = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       ascii_char = 8'h00;
    logic             char_valid = 1'b0;
    logic             sequence_valid;
    logic             output_strobe;
    logic [2:0]       err_code;
    logic [7:0]       depth;
    logic [CNT_W-1:0] ok_cnt;
    logic [CNT_W-1:0] bad_cnt;

    typedef struct {
        int code;
        int okc;
        int badc;
        int acc;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   checkCount = 0;
    int   errorCount = 0;
    int   cycleCount = 0;
    int   modelOk    = 0;
    int   modelBad   = 0;

    expr_verify #(
        .MAX_DEPTH (MAX_DEPTH),
        .MAX_DIGITS(MAX_DIGITS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ascii_char    (ascii_char),
        .char_valid    (char_valid),
        .sequence_valid(sequence_valid),
        .output_strobe (output_strobe),
        .err_code      (err_code),
        .depth         (depth),
        .ok_cnt        (ok_cnt),
        .bad_cnt       (bad_cnt)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any difference
    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Grammar model working on a token list rather than on characters
    function automatic int modelCode(input string s);
        int         kind[$];
        int         info[$];
        int         stk[$];
        bit         wantOpnd = 1'b1;
        int         i = 0;
        int         n;
        logic [7:0] c;
        while (i < s.len()) begin
            c = s[i];
            if (c >= 8'h30 && c <= 8'h39) begin
                n = 0;
                while (i < s.len() && s[i] >= 8'h30 && s[i] <= 8'h39) begin
                    n++;
                    i++;
                end
                kind.push_back(0);
                info.push_back(n);
            end else begin
                case (c)
                    8'h20: ;
                    "+", "-", "*", "/": begin kind.push_back(2); info.push_back(0); end
                    "(": begin kind.push_back(3); info.push_back(0); end
                    ")": begin kind.push_back(4); info.push_back(0); end
`ifdef EXPR_VERIFY_MULTI_BRACKET_EN
                    "[": begin kind.push_back(3); info.push_back(1); end
                    "]": begin kind.push_back(4); info.push_back(1); end
                    "{": begin kind.push_back(3); info.push_back(2); end
                    "}": begin kind.push_back(4); info.push_back(2); end
`endif
                    default: begin
                        if ((c >= "A" && c <= "Z") || (c >= "a" && c <= "z")) kind.push_back(1);
                        else kind.push_back(5);
                        info.push_back(0);
                    end
                endcase
                i++;
            end
        end
        for (int t = 0; t < kind.size(); t++) begin
            if (wantOpnd) begin
                case (kind[t])
                    0: begin
                        if (info[t] > MAX_DIGITS) return 4;
                        wantOpnd = 1'b0;
                    end
                    1: wantOpnd = 1'b0;
                    3: begin
                        if (stk.size() == MAX_DEPTH) return 3;
                        stk.push_back(info[t]);
                    end
                    default: return 1;
                endcase
            end else begin
                case (kind[t])
                    2: wantOpnd = 1'b1;
                    4: begin
                        if (stk.size() == 0) return 2;
                        if (stk[stk.size()-1] != info[t]) return 6;
                        void'(stk.pop_back());
                    end
                    default: return 1;
                endcase
            end
        end
        if (wantOpnd) return 5;
        return (stk.size() == 0) ? 0 : 5;
    endfunction

    // Random expression: mostly well-formed, sometimes with one character
    // overwritten by an arbitrary one
    function automatic string genExpr();
        string s      = "";
        string opens  = "(";
        string closes = ")";
        string ops    = "+-*/";
        string junk   = "0123456789AzQ+-*/()[]{} #@.";
        int    nTerms = $urandom_range(1, 4);
`ifdef EXPR_VERIFY_MULTI_BRACKET_EN
        opens  = "([{";
        closes = ")]}";
`endif
        for (int t = 0; t < nTerms; t++) begin
            int k;
            int n;
            int types[$];
            if (t > 0) begin
                if ($urandom_range(0, 1) == 1) s = {s, " "};
                s = $sformatf("%s%c", s, ops[$urandom_range(0, 3)]);
                if ($urandom_range(0, 1) == 1) s = {s, " "};
            end
            k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 2));
            for (int j = 0; j < k; j++) begin
                int ty;
                ty = $urandom_range(0, opens.len() - 1);
                types.push_back(ty);
                s = $sformatf("%s%c", s, opens[ty]);
            end
            if ($urandom_range(0, 2) == 0) begin
                s = $sformatf("%s%c", s, 8'h61 + $urandom_range(0, 25));
            end else begin
                n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 6)) : int'($urandom_range(1, 4));
                for (int j = 0; j < n; j++) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
            end
            while (types.size() > 0) s = $sformatf("%s%c", s, closes[types.pop_back()]);
        end
        if ($urandom_range(0, 2) == 0 && s.len() > 0) begin
            s.putc($urandom_range(0, s.len() - 1), junk[$urandom_range(0, junk.len() - 1)]);
        end
        return s;
    endfunction

    // Present one character for exactly one clock edge
    task automatic applyStimulus(input logic [7:0] c);
        @(negedge clk);
        ascii_char = c;
        char_valid = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            char_valid = 1'b0;
        end
    endtask

    // Send "\0<body>\0" and queue the model's verdict. The closing NUL is
    // accepted on the next rising edge, i.e. edge number cycleCount+1.
    task automatic sendFrame(input string body, input int maxGap);
        exp_t e;
        applyStimulus(8'h00);
        idleCycles($urandom_range(0, maxGap));
        for (int i = 0; i < body.len(); i++) begin
            applyStimulus(body[i]);
            idleCycles($urandom_range(0, maxGap));
        end
        applyStimulus(8'h00);
        e.code = modelCode(body);
        if (e.code == 0) modelOk  = (modelOk + 1) % (1 << CNT_W);
        else             modelBad = (modelBad + 1) % (1 << CNT_W);
        e.okc  = modelOk;
        e.badc = modelBad;
        e.acc  = cycleCount + 1;
        expQ.push_back(e);
    endtask

    task automatic waitDrained();
        int budget = 50;
        idleCycles(1);
        while (expQ.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (expQ.size() != 0) begin
            checkOutput("drain_timeout", expQ.size(), 0);
            expQ.delete();
        end
    endtask

    // Strobe monitor: every strobe must match the oldest pending frame
    always begin
        @(posedge clk);
        cycleCount++;
        #1;
        if (rst && output_strobe) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_strobe", 1, 0);
            end else begin
                monE = expQ.pop_front();
                checkOutput("strobe_latency", cycleCount, monE.acc + 1);
                checkOutput("err_code", err_code, monE.code);
                checkOutput("sequence_valid", sequence_valid, (monE.code == 0) ? 1 : 0);
                checkOutput("ok_cnt", ok_cnt, monE.okc);
                checkOutput("bad_cnt", bad_cnt, monE.badc);
            end
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset values
        idleCycles(2);
        checkOutput("rst_sequence_valid", sequence_valid, 0);
        checkOutput("rst_output_strobe", output_strobe, 0);
        checkOutput("rst_err_code", err_code, 0);
        checkOutput("rst_depth", depth, 0);
        checkOutput("rst_ok_cnt", ok_cnt, 0);
        checkOutput("rst_bad_cnt", bad_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        // Directed frames, back-to-back where grouped
        sendFrame("(1+2)", 0);
        waitDrained();
        sendFrame("(A*B)", 0);
        sendFrame("(1+2", 0);
        waitDrained();
        checkOutput("depth_cleared", depth, 0);
        sendFrame("((((((((((1))))))))))", 0);
        sendFrame("12345", 0);
        sendFrame("1234", 0);
        sendFrame("1+)", 0);
        sendFrame("(1))", 0);
        sendFrame("AB", 0);
        sendFrame("", 0);
        sendFrame("[1]", 0);
        sendFrame("{[1]*(2)}", 0);
        sendFrame("(1]", 0);
        sendFrame("( 7 - x ) / 12", 1);
        sendFrame("1 2", 0);
        waitDrained();

        // Reset in the middle of a frame discards it
        applyStimulus(8'h00);
        applyStimulus("(");
        applyStimulus("(");
        applyStimulus("1");
        applyStimulus("+");
        idleCycles(1);
        checkOutput("depth_mid_frame", depth, 2);
        @(negedge clk);
        rst = 1'b0;
        idleCycles(2);
        checkOutput("abort_depth", depth, 0);
        checkOutput("abort_ok_cnt", ok_cnt, 0);
        checkOutput("abort_bad_cnt", bad_cnt, 0);
        modelOk  = 0;
        modelBad = 0;
        @(negedge clk);
        rst = 1'b1;
        sendFrame("7", 0);
        waitDrained();

        // Random frames with gaps and ignored junk between frames
        for (int f = 0; f < 250; f++) begin
            if ($urandom_range(0, 4) == 0) applyStimulus("x");
            sendFrame(genExpr(), 2);
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
        end
        waitDrained();

        // Enough empty frames to wrap the invalid-frame counter
        for (int f = 0; f < 260; f++) sendFrame("", 0);
        waitDrained();

        checkOutput("final_ok_cnt", ok_cnt, modelOk);
        checkOutput("final_bad_cnt", bad_cnt, modelBad);
        checkOutput("final_pending", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
